axi4lite_regbank_v2: RTL and testbench

Parametrised AXI4-Lite slave register bank. It exposes a bank of control registers (`reg_out`) and a bank of status registers (`reg_in`) to a processor, behind a fixed identification header. Compared with the first-generation bank it adds:
- independent AW/W channel acceptance
- WSTRB byte-lane writes
- SLVERR on undecoded or illegal accesses
- per-register write and read strobes for the user logic

---
 rtl/axi4lite_regbank_v2.sv | 209 ++++++++++++++++++++
 tb/tb_axi4lite_regbank_v2.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_regbank_v2.sv
// AXI4-Lite register bank: ID/CONFIG/SCRATCH header, RW control words at 0x100,
// RO status words at 0x200, with byte-lane writes, SLVERR decode and user strobes.
module axi4lite_regbank_v2 #(
    parameter int unsigned NOF_REGOUT = 4,
    parameter int unsigned NOF_REGIN  = 4,
    parameter int unsigned ADDR_W     = 12,
    parameter logic [31:0] ID_VALUE   = 32'hDEADBEEF,
    parameter logic [31:0] REGOUT_RST = 32'h0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         ctrl_arvalid,
    output logic                         ctrl_arready,
    input  logic [ADDR_W-1:0]            ctrl_araddr,
    output logic                         ctrl_rvalid,
    input  logic                         ctrl_rready,
    output logic [31:0]                  ctrl_rdata,
    output logic [1:0]                   ctrl_rresp,
    input  logic                         ctrl_awvalid,
    output logic                         ctrl_awready,
    input  logic [ADDR_W-1:0]            ctrl_awaddr,
    input  logic                         ctrl_wvalid,
    output logic                         ctrl_wready,
    input  logic [31:0]                  ctrl_wdata,
    input  logic [3:0]                   ctrl_wstrb,
    output logic                         ctrl_bvalid,
    input  logic                         ctrl_bready,
    output logic [1:0]                   ctrl_bresp,
    output logic [NOF_REGOUT-1:0][31:0]  reg_out,
    input  logic [NOF_REGIN-1:0][31:0]   reg_in,
    output logic [NOF_REGOUT-1:0]        reg_wr_pulse,
    output logic [NOF_REGIN-1:0]         reg_rd_pulse
);
    localparam int unsigned WA_W = ADDR_W - 2;
    localparam int unsigned PG_W = ADDR_W - 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rd_rsp_t;

    logic                        aw_full_q;
    logic [WA_W-1:0]             awaddr_q;
    logic                        w_full_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  wstrb_q;
    logic                        bvalid_q;
    logic [1:0]                  bresp_q;
    logic                        rvalid_q;
    logic [31:0]                 rdata_q;
    logic [1:0]                  rresp_q;
    logic [31:0]                 scratch_q;
    logic [NOF_REGOUT-1:0][31:0] reg_out_q;
    logic [NOF_REGOUT-1:0]       wr_pulse_q;
    logic [NOF_REGIN-1:0]        rd_pulse_q;

    // Readies come from state only, so no valid-to-ready combinational path exists.
    assign ctrl_arready = !areset && !rvalid_q;
    assign ctrl_awready = !areset && !aw_full_q;
    assign ctrl_wready  = !areset && !w_full_q;

    assign ctrl_rvalid  = rvalid_q;
    assign ctrl_rdata   = rdata_q;
    assign ctrl_rresp   = rresp_q;
    assign ctrl_bvalid  = bvalid_q;
    assign ctrl_bresp   = bresp_q;
    assign reg_out      = reg_out_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_rd_pulse = rd_pulse_q;

    logic aw_hs, w_hs, ar_hs, commit;
    assign aw_hs  = ctrl_awvalid && ctrl_awready;
    assign w_hs   = ctrl_wvalid && ctrl_wready;
    assign ar_hs  = ctrl_arvalid && ctrl_arready;
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ctrl_araddr[1:0], ctrl_awaddr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
        return m;
    endfunction

    logic [PG_W-1:0]       wpage;
    logic [5:0]            woff;
    logic                  wr_err_c;
    logic                  scratch_wr_c;
    logic [NOF_REGOUT-1:0] wr_sel_c;

    assign wpage = awaddr_q[WA_W-1:6];
    assign woff  = awaddr_q[5:0];

    // Header page writes other than SCRATCH are silently dropped with OKAY.
    always_comb begin
        wr_err_c     = 1'b1;
        scratch_wr_c = 1'b0;
        wr_sel_c     = '0;
        if (wpage == '0) begin
            wr_err_c     = 1'b0;
            scratch_wr_c = (woff == 6'd2);
        end else if (wpage == PG_W'(1)) begin
            for (int i = 0; i < NOF_REGOUT; i++)
                if (woff == 6'(i)) begin
                    wr_sel_c[i] = 1'b1;
                    wr_err_c    = 1'b0;
                end
        end
    end

    logic [PG_W-1:0]      rpage;
    logic [5:0]           roff;
    rd_rsp_t              rd_c;
    logic [NOF_REGIN-1:0] rd_sel_c;

    assign rpage = ctrl_araddr[ADDR_W-1:8];
    assign roff  = ctrl_araddr[7:2];

    always_comb begin
        rd_c.err  = 1'b1;
        rd_c.data = '0;
        rd_sel_c  = '0;
        if (rpage == '0) begin
            rd_c.err = 1'b0;
            case (roff)
                6'd0:    rd_c.data = ID_VALUE;
                6'd1:    rd_c.data = {16'(NOF_REGIN), 16'(NOF_REGOUT)};
                6'd2:    rd_c.data = scratch_q;
                default: rd_c.data = '0;
            endcase
        end else if (rpage == PG_W'(1)) begin
            for (int i = 0; i < NOF_REGOUT; i++)
                if (roff == 6'(i)) begin
                    rd_c.err  = 1'b0;
                    rd_c.data = reg_out_q[i];
                end
        end else if (rpage == PG_W'(2)) begin
            for (int i = 0; i < NOF_REGIN; i++)
                if (roff == 6'(i)) begin
                    rd_c.err    = 1'b0;
                    rd_c.data   = reg_in[i];
                    rd_sel_c[i] = 1'b1;
                end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_full_q  <= 1'b0;
            awaddr_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            scratch_q  <= '0;
            reg_out_q  <= {NOF_REGOUT{REGOUT_RST}};
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;

            if (commit) begin
                aw_full_q  <= 1'b0;
                w_full_q   <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
                wr_pulse_q <= wr_sel_c;
                if (scratch_wr_c)
                    scratch_q <= merge(scratch_q, wdata_q, wstrb_q);
                for (int i = 0; i < NOF_REGOUT; i++)
                    if (wr_sel_c[i])
                        reg_out_q[i] <= merge(reg_out_q[i], wdata_q, wstrb_q);
            end else if (bvalid_q && ctrl_bready) begin
                bvalid_q <= 1'b0;
            end

            if (aw_hs) begin
                aw_full_q <= 1'b1;
                awaddr_q  <= ctrl_awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= ctrl_wdata;
                wstrb_q  <= ctrl_wstrb;
            end

            if (ar_hs) begin
                rvalid_q   <= 1'b1;
                rdata_q    <= rd_c.data;
                rresp_q    <= rd_c.err ? RESP_SLVERR : RESP_OKAY;
                rd_pulse_q <= rd_sel_c;
            end else if (rvalid_q && ctrl_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_regbank_v2.sv
// Directed bench for axi4lite_regbank_v2 with default parameters (4 out / 4 in, 12-bit address).
module tb_axi4lite_regbank_v2;
    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             ctrl_arvalid = 1'b0;
    logic             ctrl_arready;
    logic [11:0]      ctrl_araddr = '0;
    logic             ctrl_rvalid;
    logic             ctrl_rready = 1'b0;
    logic [31:0]      ctrl_rdata;
    logic [1:0]       ctrl_rresp;
    logic             ctrl_awvalid = 1'b0;
    logic             ctrl_awready;
    logic [11:0]      ctrl_awaddr = '0;
    logic             ctrl_wvalid = 1'b0;
    logic             ctrl_wready;
    logic [31:0]      ctrl_wdata = '0;
    logic [3:0]       ctrl_wstrb = '0;
    logic             ctrl_bvalid;
    logic             ctrl_bready = 1'b0;
    logic [1:0]       ctrl_bresp;
    logic [3:0][31:0] reg_out;
    logic [3:0][31:0] reg_in;
    logic [3:0]       reg_wr_pulse;
    logic [3:0]       reg_rd_pulse;

    int n_chk = 0;
    int n_fail = 0;

    axi4lite_regbank_v2 dut (
        .aclk(aclk), .areset(areset),
        .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready), .ctrl_araddr(ctrl_araddr),
        .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready), .ctrl_rdata(ctrl_rdata),
        .ctrl_rresp(ctrl_rresp),
        .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready), .ctrl_awaddr(ctrl_awaddr),
        .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready), .ctrl_wdata(ctrl_wdata),
        .ctrl_wstrb(ctrl_wstrb),
        .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready), .ctrl_bresp(ctrl_bresp),
        .reg_out(reg_out), .reg_in(reg_in),
        .reg_wr_pulse(reg_wr_pulse), .reg_rd_pulse(reg_rd_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // m[0]: wait on awready, m[1]: wait on wready; handshake happens at the next edge.
    task automatic wait_rdy(input logic [1:0] m);
        int n = 0;
        while (((m[0] && !ctrl_awready) || (m[1] && !ctrl_wready)) && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("w_hs_timeout", 32'(n < 50), 1);
        @(posedge aclk); #1;
        if (m[0]) ctrl_awvalid = 1'b0;
        if (m[1]) ctrl_wvalid = 1'b0;
    endtask

    // mode 0: AW and W together, 1: AW three cycles ahead of W, 2: W three cycles ahead of AW
    task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, output logic [1:0] resp, output logic [3:0] pulse);
        ctrl_awaddr = a;
        ctrl_wdata  = d;
        ctrl_wstrb  = s;
        if (mode == 0) begin
            ctrl_awvalid = 1'b1;
            ctrl_wvalid  = 1'b1;
            wait_rdy(2'b11);
        end else begin
            if (mode == 1) ctrl_awvalid = 1'b1; else ctrl_wvalid = 1'b1;
            wait_rdy(mode == 1 ? 2'b01 : 2'b10);
            repeat (3) begin
                @(posedge aclk); #1;
                chk("no_early_b", ctrl_bvalid, 0);
            end
            if (mode == 1) ctrl_wvalid = 1'b1; else ctrl_awvalid = 1'b1;
            wait_rdy(mode == 1 ? 2'b10 : 2'b01);
        end
        chk("b_not_yet", ctrl_bvalid, 0);
        @(posedge aclk); #1;
        chk("b_latency", ctrl_bvalid, 1);
        resp  = ctrl_bresp;
        pulse = reg_wr_pulse;
        ctrl_bready = 1'b1;
        @(posedge aclk); #1;
        ctrl_bready = 1'b0;
        chk("b_done", ctrl_bvalid, 0);
        chk("wr_pulse_1cyc", reg_wr_pulse, 0);
    endtask

    task automatic axi_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r,
                          output logic [3:0] p);
        int n = 0;
        ctrl_araddr  = a;
        ctrl_arvalid = 1'b1;
        while (!ctrl_arready && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("ar_timeout", 32'(n < 50), 1);
        @(posedge aclk); #1;
        ctrl_arvalid = 1'b0;
        chk("r_latency", ctrl_rvalid, 1);
        d = ctrl_rdata;
        r = ctrl_rresp;
        p = reg_rd_pulse;
        ctrl_rready = 1'b1;
        @(posedge aclk); #1;
        ctrl_rready = 1'b0;
        chk("r_done", ctrl_rvalid, 0);
        chk("rd_pulse_1cyc", reg_rd_pulse, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  p;
        logic [31:0] exp_out [4];

        reg_in[0] = 32'h0000_0010;
        reg_in[1] = 32'h0000_0011;
        reg_in[2] = 32'h0000_0012;
        reg_in[3] = 32'h0000_0013;

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", ctrl_arready, 0);
        chk("rst_awready", ctrl_awready, 0);
        chk("rst_wready", ctrl_wready, 0);
        areset = 1'b0;
        #1;
        chk("post_rst_arready", ctrl_arready, 1);
        chk("post_rst_bvalid", ctrl_bvalid, 0);
        chk("post_rst_rvalid", ctrl_rvalid, 0);
        for (int i = 0; i < 4; i++) chk("rst_reg_out", reg_out[i], 32'h0);
        @(posedge aclk); #1;

        axi_rd(12'h000, d, r, p);
        chk("id_data", d, 32'hDEADBEEF);
        chk("id_resp", r, 2'b00);
        axi_rd(12'h004, d, r, p);
        chk("cfg_data", d, 32'h0004_0004);
        chk("cfg_resp", r, 2'b00);
        axi_rd(12'h008, d, r, p);
        chk("scratch_rst", d, 32'h0);
        chk("scratch_resp", r, 2'b00);

        // channel ordering
        axi_wr(12'h104, 32'h12345678, 4'hF, 1, r, p);
        chk("awfirst_resp", r, 2'b00);
        chk("awfirst_pulse", p, 4'b0010);
        chk("awfirst_reg", reg_out[1], 32'h12345678);
        axi_wr(12'h108, 32'h0BADF00D, 4'hF, 2, r, p);
        chk("wfirst_resp", r, 2'b00);
        chk("wfirst_pulse", p, 4'b0100);
        chk("wfirst_reg", reg_out[2], 32'h0BADF00D);
        axi_wr(12'h10C, 32'hA5A5C3C3, 4'hF, 0, r, p);
        chk("same_resp", r, 2'b00);
        chk("same_pulse", p, 4'b1000);
        chk("same_reg", reg_out[3], 32'hA5A5C3C3);

        // byte lanes
        axi_wr(12'h100, 32'h11223344, 4'hF, 0, r, p);
        chk("bl_full", reg_out[0], 32'h11223344);
        axi_wr(12'h100, 32'hAABBCCDD, 4'b0101, 0, r, p);
        chk("bl_merge", reg_out[0], 32'h11BB33DD);
        axi_wr(12'h100, 32'hFFFFFFFF, 4'b0000, 1, r, p);
        chk("strb0_resp", r, 2'b00);
        chk("strb0_pulse", p, 4'b0001);
        chk("strb0_reg", reg_out[0], 32'h11BB33DD);

        // header writes
        axi_wr(12'h008, 32'h5A5A5A5A, 4'hF, 0, r, p);
        chk("scratch_wr_pulse", p, 4'b0000);
        axi_rd(12'h008, d, r, p);
        chk("scratch_rd", d, 32'h5A5A5A5A);
        axi_wr(12'h000, 32'h0, 4'hF, 0, r, p);
        chk("id_wr_resp", r, 2'b00);
        axi_rd(12'h000, d, r, p);
        chk("id_unchanged", d, 32'hDEADBEEF);
        axi_rd(12'h0F0, d, r, p);
        chk("hole_data", d, 32'h0);
        chk("hole_resp", r, 2'b00);

        // status and control readback
        reg_in[2] = 32'hCAFE0002;
        axi_rd(12'h208, d, r, p);
        chk("st_data", d, 32'hCAFE0002);
        chk("st_resp", r, 2'b00);
        chk("st_pulse", p, 4'b0100);
        axi_rd(12'h104, d, r, p);
        chk("ctl_rd", d, 32'h12345678);
        chk("ctl_rd_pulse", p, 4'b0000);

        // errors
        axi_rd(12'h110, d, r, p);
        chk("err_rd110_resp", r, 2'b10);
        chk("err_rd110_data", d, 32'h0);
        axi_rd(12'h210, d, r, p);
        chk("err_rd210_resp", r, 2'b10);
        chk("err_rd210_pulse", p, 4'b0000);
        axi_rd(12'h400, d, r, p);
        chk("err_rd400_resp", r, 2'b10);
        axi_wr(12'h200, 32'hDEAD0000, 4'hF, 0, r, p);
        chk("err_wr200_resp", r, 2'b10);
        chk("err_wr200_pulse", p, 4'b0000);
        axi_wr(12'h110, 32'hDEAD0001, 4'hF, 0, r, p);
        chk("err_wr110_resp", r, 2'b10);
        axi_wr(12'h300, 32'hDEAD0002, 4'hF, 2, r, p);
        chk("err_wr300_resp", r, 2'b10);
        chk("err_wr300_pulse", p, 4'b0000);
        exp_out[0] = 32'h11BB33DD;
        exp_out[1] = 32'h12345678;
        exp_out[2] = 32'h0BADF00D;
        exp_out[3] = 32'hA5A5C3C3;
        for (int i = 0; i < 4; i++) chk("err_regs_kept", reg_out[i], exp_out[i]);

        // backpressure: one committed write waiting on bready plus one buffered write
        ctrl_awaddr  = 12'h104;
        ctrl_wdata   = 32'hFEEDFACE;
        ctrl_wstrb   = 4'hF;
        ctrl_awvalid = 1'b1;
        ctrl_wvalid  = 1'b1;
        @(posedge aclk); #1;
        ctrl_awaddr = 12'h108;
        ctrl_wdata  = 32'h01020304;
        chk("bp_full_awready", ctrl_awready, 0);
        @(posedge aclk); #1;
        chk("bp_commit_b", ctrl_bvalid, 1);
        chk("bp_commit_pulse", reg_wr_pulse, 4'b0010);
        @(posedge aclk); #1;
        ctrl_awvalid = 1'b0;
        ctrl_wvalid  = 1'b0;
        ctrl_araddr  = 12'h208;
        ctrl_arvalid = 1'b1;
        @(posedge aclk); #1;
        ctrl_arvalid = 1'b0;
        reg_in[2] = 32'h77777777;
        for (int c = 0; c < 10; c++) begin
            @(posedge aclk); #1;
            chk("bp_bvalid", ctrl_bvalid, 1);
            chk("bp_bresp", ctrl_bresp, 2'b00);
            chk("bp_rvalid", ctrl_rvalid, 1);
            chk("bp_rdata", ctrl_rdata, 32'hCAFE0002);
            chk("bp_reg1", reg_out[1], 32'hFEEDFACE);
            chk("bp_reg2_held", reg_out[2], 32'h0BADF00D);
            chk("bp_awready", ctrl_awready, 0);
            chk("bp_wready", ctrl_wready, 0);
        end

        // reset with a response pending and a write buffered
        areset = 1'b1;
        #1;
        chk("mid_rst_arready", ctrl_arready, 0);
        chk("mid_rst_awready", ctrl_awready, 0);
        chk("mid_rst_wready", ctrl_wready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        chk("mid_rst_bvalid", ctrl_bvalid, 0);
        chk("mid_rst_rvalid", ctrl_rvalid, 0);
        for (int i = 0; i < 4; i++) chk("mid_rst_reg_out", reg_out[i], 32'h0);
        ctrl_bready = 1'b1;
        ctrl_rready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge aclk); #1;
            chk("stale_bvalid", ctrl_bvalid, 0);
            chk("stale_rvalid", ctrl_rvalid, 0);
            chk("stale_pulse", reg_wr_pulse, 4'b0000);
            chk("stale_reg2", reg_out[2], 32'h0);
        end
        ctrl_bready = 1'b0;
        ctrl_rready = 1'b0;
        axi_rd(12'h008, d, r, p);
        chk("rst_scratch", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
